// File: rtl/uart_cfg_ctrl.sv
// Boot-time programmer for uart_regs followed by a serialised host register port.
// Define UART_CFG_FIFO_EN to include the FIFO-control write (W_FCR) in the init sequence.
`ifndef UART_ADDR_WIDTH
`define UART_ADDR_WIDTH 3
`endif

module uart_cfg_ctrl #(
    parameter logic [15:0] DIVISOR  = 16'd27,
    parameter logic [7:0]  LCR_INIT = 8'h03,
    parameter logic [7:0]  FCR_INIT = 8'hC0,
    parameter logic [3:0]  IER_INIT = 4'h0,
    parameter logic [4:0]  MCR_INIT = 5'h03
) (
    input  logic                        clk,
    input  logic                        wb_rst_i,
    input  logic                        host_req_i,
    input  logic                        host_we_i,
    input  logic [`UART_ADDR_WIDTH-1:0] host_addr_i,
    input  logic [7:0]                  host_dat_i,
    output logic [7:0]                  host_dat_o,
    output logic                        host_ack_o,
    input  logic                        reinit_i,
    output logic                        init_done_o,
    output logic [`UART_ADDR_WIDTH-1:0] uart_addr_o,
    output logic [7:0]                  uart_dat_o,
    output logic                        uart_we_o,
    output logic                        uart_re_o,
    input  logic [7:0]                  uart_dat_i
);
    localparam int AW = `UART_ADDR_WIDTH;
    localparam logic [AW-1:0] ADDR_TR = AW'(0);
    localparam logic [AW-1:0] ADDR_IE = AW'(1);
    localparam logic [AW-1:0] ADDR_FC = AW'(2);
    localparam logic [AW-1:0] ADDR_LC = AW'(3);
    localparam logic [AW-1:0] ADDR_MC = AW'(4);

    typedef enum logic [3:0] {
        BOOT,
        W_LCRD,
        W_DLL,
        W_DLM,
        W_LCR,
`ifdef UART_CFG_FIFO_EN
        W_FCR,
`endif
        W_IER,
        W_MCR,
        RUN
    } state_t;

    typedef enum logic [1:0] {
        H_IDLE,
        H_ACC,
        H_WAIT,
        H_ACK
    } host_state_t;

    state_t                state_reg;
    host_state_t           host_state_reg;
    logic                  pending_reg;
    logic                  init_done_reg;
    logic                  host_ack_reg;
    logic [7:0]            host_dat_reg;
    logic [AW-1:0]         uart_addr_reg;
    logic [7:0]            uart_dat_reg;
    logic                  uart_we_reg;
    logic                  uart_re_reg;

    state_t                seq_next;
    logic [AW-1:0]         seq_addr;
    logic [7:0]            seq_dat;
    logic                  reinit_accept;
    logic                  pending_next;

`ifndef UART_CFG_FIFO_EN
    // Without FIFO support the UART keeps its reset FCR, so this value goes nowhere.
    logic [7:0] fcr_unused;
    assign fcr_unused = FCR_INIT;
`endif

    // Successor of the current init state and the register write performed in it.
    // RUN maps to W_LCRD so reinit acceptance reuses the first write of the sequence.
    always_comb begin
        seq_next = RUN;
        seq_addr = ADDR_LC;
        seq_dat  = 8'h80 | LCR_INIT;
        case (state_reg)
            BOOT:   begin seq_next = W_LCRD; seq_addr = ADDR_LC; seq_dat = 8'h80 | LCR_INIT; end
            W_LCRD: begin seq_next = W_DLL;  seq_addr = ADDR_TR; seq_dat = DIVISOR[7:0];     end
            W_DLL:  begin seq_next = W_DLM;  seq_addr = ADDR_IE; seq_dat = DIVISOR[15:8];    end
`ifdef UART_CFG_FIFO_EN
            W_DLM:  begin seq_next = W_LCR;  seq_addr = ADDR_LC; seq_dat = LCR_INIT & 8'h7F; end
            W_LCR:  begin seq_next = W_FCR;  seq_addr = ADDR_FC; seq_dat = FCR_INIT | 8'h06; end
            W_FCR:  begin seq_next = W_IER;  seq_addr = ADDR_IE; seq_dat = {4'h0, IER_INIT}; end
`else
            W_DLM:  begin seq_next = W_LCR;  seq_addr = ADDR_LC; seq_dat = LCR_INIT & 8'h7F; end
            W_LCR:  begin seq_next = W_IER;  seq_addr = ADDR_IE; seq_dat = {4'h0, IER_INIT}; end
`endif
            W_IER:  begin seq_next = W_MCR;  seq_addr = ADDR_MC; seq_dat = {3'b000, MCR_INIT}; end
            W_MCR:  begin seq_next = RUN;    seq_addr = ADDR_LC; seq_dat = 8'h80 | LCR_INIT; end
            RUN:    begin seq_next = W_LCRD; seq_addr = ADDR_LC; seq_dat = 8'h80 | LCR_INIT; end
            default: begin seq_next = RUN;   seq_addr = ADDR_LC; seq_dat = 8'h80 | LCR_INIT; end
        endcase
    end

    assign reinit_accept = (state_reg == RUN) && (host_state_reg == H_IDLE) && pending_reg;
    assign pending_next  = (pending_reg & ~reinit_accept) | reinit_i;

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_reg      <= BOOT;
            host_state_reg <= H_IDLE;
            pending_reg    <= 1'b0;
            init_done_reg  <= 1'b0;
            host_ack_reg   <= 1'b0;
            host_dat_reg   <= 8'h00;
            uart_addr_reg  <= '0;
            uart_dat_reg   <= 8'h00;
            uart_we_reg    <= 1'b0;
            uart_re_reg    <= 1'b0;
        end else begin
            uart_we_reg  <= 1'b0;
            uart_re_reg  <= 1'b0;
            host_ack_reg <= 1'b0;
            pending_reg  <= pending_next;
            if (state_reg != RUN) begin
                state_reg <= seq_next;
                if (seq_next == RUN) begin
                    // A reinit latched during the sequence keeps done low and restarts at once.
                    init_done_reg <= ~pending_next;
                end else begin
                    uart_we_reg   <= 1'b1;
                    uart_addr_reg <= seq_addr;
                    uart_dat_reg  <= seq_dat;
                end
            end else begin
                case (host_state_reg)
                    H_IDLE: begin
                        if (pending_reg) begin
                            state_reg     <= W_LCRD;
                            init_done_reg <= 1'b0;
                            uart_we_reg   <= 1'b1;
                            uart_addr_reg <= seq_addr;
                            uart_dat_reg  <= seq_dat;
                        end else if (host_req_i) begin
                            host_state_reg <= H_ACC;
                            uart_we_reg    <= host_we_i;
                            uart_re_reg    <= ~host_we_i;
                            uart_addr_reg  <= host_addr_i;
                            uart_dat_reg   <= host_dat_i;
                        end
                    end
                    H_ACC: begin
                        // The strobe still visible this cycle tells which access is in flight.
                        if (uart_we_reg) begin
                            host_state_reg <= H_ACK;
                            host_ack_reg   <= 1'b1;
                        end else begin
                            host_state_reg <= H_WAIT;
                        end
                    end
                    H_WAIT: begin
                        host_dat_reg   <= uart_dat_i;
                        host_ack_reg   <= 1'b1;
                        host_state_reg <= H_ACK;
                    end
                    H_ACK: begin
                        host_state_reg <= H_IDLE;
                    end
                    default: begin
                        host_state_reg <= H_IDLE;
                    end
                endcase
            end
        end
    end

    assign host_dat_o  = host_dat_reg;
    assign host_ack_o  = host_ack_reg;
    assign init_done_o = init_done_reg;
    assign uart_addr_o = uart_addr_reg;
    assign uart_dat_o  = uart_dat_reg;
    assign uart_we_o   = uart_we_reg;
    assign uart_re_o   = uart_re_reg;

endmodule

// File: tb/tb_uart_cfg_ctrl.sv
// Scoreboard bench for uart_cfg_ctrl: expected uart strobes, host acks and init_done edges
// are queued with their cycle numbers and checked by an independent negedge monitor.
`ifndef UART_ADDR_WIDTH
`define UART_ADDR_WIDTH 3
`endif

module tb_uart_cfg_ctrl;
    localparam int AW = `UART_ADDR_WIDTH;
    localparam logic [15:0] DIV  = 16'h0102;
    localparam logic [7:0]  LCR  = 8'h03;
    localparam logic [7:0]  FCR  = 8'hC0;
    localparam logic [3:0]  IER  = 4'h0;
    localparam logic [4:0]  MCR  = 5'h03;
`ifdef UART_CFG_FIFO_EN
    localparam int NW = 7;
`else
    localparam int NW = 6;
`endif

    logic          clk = 1'b0;
    logic          wb_rst_i = 1'b1;
    logic          host_req_i = 1'b0;
    logic          host_we_i = 1'b0;
    logic [AW-1:0] host_addr_i = '0;
    logic [7:0]    host_dat_i = 8'h00;
    logic [7:0]    host_dat_o;
    logic          host_ack_o;
    logic          reinit_i = 1'b0;
    logic          init_done_o;
    logic [AW-1:0] uart_addr_o;
    logic [7:0]    uart_dat_o;
    logic          uart_we_o;
    logic          uart_re_o;
    logic [7:0]    uart_dat_i = 8'h00;

    uart_cfg_ctrl #(
        .DIVISOR (DIV),
        .LCR_INIT(LCR),
        .FCR_INIT(FCR),
        .IER_INIT(IER),
        .MCR_INIT(MCR)
    ) dut (
        .clk        (clk),
        .wb_rst_i   (wb_rst_i),
        .host_req_i (host_req_i),
        .host_we_i  (host_we_i),
        .host_addr_i(host_addr_i),
        .host_dat_i (host_dat_i),
        .host_dat_o (host_dat_o),
        .host_ack_o (host_ack_o),
        .reinit_i   (reinit_i),
        .init_done_o(init_done_o),
        .uart_addr_o(uart_addr_o),
        .uart_dat_o (uart_dat_o),
        .uart_we_o  (uart_we_o),
        .uart_re_o  (uart_re_o),
        .uart_dat_i (uart_dat_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [7:0]    dat;
        int            cyc;
    } acc_t;

    typedef struct {
        logic [7:0] dat;
        int         cyc;
    } ack_t;

    acc_t uq[$];
    ack_t aq[$];
    int   rise_q[$];
    int   fall_q[$];

    int         total = 0;
    int         bad = 0;
    int         free_cyc = 0;
    logic [7:0] last_rd = 8'h00;
    int         base;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // The init program as stated: LC+DLAB, DLL, DLM, LC, [FC], IE, MC.
    task automatic push_init(input int start, input int n);
        acc_t seq[$];
        acc_t e;
        seq.push_back('{1'b1, AW'(3), 8'h80 | LCR, 0});
        seq.push_back('{1'b1, AW'(0), DIV[7:0], 0});
        seq.push_back('{1'b1, AW'(1), DIV[15:8], 0});
        seq.push_back('{1'b1, AW'(3), LCR & 8'h7F, 0});
`ifdef UART_CFG_FIFO_EN
        seq.push_back('{1'b1, AW'(2), FCR | 8'h06, 0});
`endif
        seq.push_back('{1'b1, AW'(1), {4'h0, IER}, 0});
        seq.push_back('{1'b1, AW'(4), {3'b000, MCR}, 0});
        for (int i = 0; i < n; i++) begin
            e = seq[i];
            e.cyc = start + 1 + i;
            uq.push_back(e);
        end
    endtask

    task automatic start_init(input int b);
        push_init(b, NW);
        rise_q.push_back(b + NW + 1);
        free_cyc = b + NW + 1;
    endtask

    // Called #1 after a rising edge; asserts reset there, checks outputs, releases two cycles later.
    task automatic do_reset(output int b);
        wb_rst_i = 1'b1;
        host_req_i = 1'b0;
        reinit_i = 1'b0;
        #1;
        chk("rst_host_dat", host_dat_o, 0);
        chk("rst_host_ack", host_ack_o, 0);
        chk("rst_init_done", init_done_o, 0);
        chk("rst_uart_addr", uart_addr_o, 0);
        chk("rst_uart_dat", uart_dat_o, 0);
        chk("rst_uart_we", uart_we_o, 0);
        chk("rst_uart_re", uart_re_o, 0);
        chk("rst_leftover", uq.size() + aq.size() + rise_q.size() + fall_q.size(), 0);
        uq.delete();
        aq.delete();
        rise_q.delete();
        fall_q.delete();
        last_rd = 8'h00;
        repeat (2) @(posedge clk);
        #1 wb_rst_i = 1'b0;
        b = cyc;
        $display("reset released, BOOT cycle %0d", b);
    endtask

    task automatic host_access(input logic we, input logic [AW-1:0] addr, input logic [7:0] dat,
                               input logic [7:0] rdv, input logic early, input logic rein);
        int n;
        int k;
        if (!early) begin
            while (cyc < free_cyc) begin
                @(posedge clk);
                #1;
            end
        end
        host_req_i  = 1'b1;
        host_we_i   = we;
        host_addr_i = addr;
        host_dat_i  = dat;
        uart_dat_i  = we ? 8'($urandom) : rdv;
        n = (cyc > free_cyc) ? cyc : free_cyc;
        uq.push_back('{we, addr, dat, n + 1});
        if (we) begin
            aq.push_back('{last_rd, n + 2});
            free_cyc = n + 3;
        end else begin
            aq.push_back('{rdv, n + 3});
            last_rd = rdv;
            free_cyc = n + 4;
        end
        $display("host %s addr=%0h dat=%0h sample cycle %0d", we ? "write" : "read", addr,
                 we ? dat : rdv, n);
        if (rein) begin
            // Reinit lands while the access is in flight; it is honoured at the next idle cycle.
            fall_q.push_back(free_cyc + 1);
            push_init(free_cyc, NW);
            rise_q.push_back(free_cyc + NW + 1);
            free_cyc = free_cyc + NW + 1;
            @(posedge clk);
            #1 reinit_i = 1'b1;
            @(posedge clk);
            #1 reinit_i = 1'b0;
        end
        k = 0;
        while (!host_ack_o && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!host_ack_o) begin
            total++;
            bad++;
            $display("FAIL ack_timeout: got no host_ack_o required ack within 100 cycles");
        end
        @(posedge clk);
        #1;
        host_req_i = 1'b0;
        uart_dat_i = 8'($urandom);
    endtask

    acc_t mon_u;
    ack_t mon_a;
    logic prev_done = 1'b0;

    always @(negedge clk) begin
        if (!wb_rst_i) begin
            if (uart_we_o || uart_re_o) begin
                if (uq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_strobe: got we=%0b re=%0b addr=%0h cycle %0d required none",
                             uart_we_o, uart_re_o, uart_addr_o, cyc);
                end else begin
                    mon_u = uq.pop_front();
                    chk("strobe_excl", {31'b0, uart_we_o & uart_re_o}, 0);
                    chk("strobe_cycle", cyc, mon_u.cyc);
                    chk("strobe_we", {31'b0, uart_we_o}, {31'b0, mon_u.we});
                    chk("strobe_addr", 32'(uart_addr_o), 32'(mon_u.addr));
                    if (mon_u.we) chk("strobe_data", {24'b0, uart_dat_o}, {24'b0, mon_u.dat});
                    $display("uart %s cycle=%0d addr=%0h dat=%0h", uart_we_o ? "wr" : "rd", cyc,
                             uart_addr_o, uart_dat_o);
                end
            end
            if (host_ack_o) begin
                if (aq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ack: got ack cycle %0d required none", cyc);
                end else begin
                    mon_a = aq.pop_front();
                    chk("ack_cycle", cyc, mon_a.cyc);
                    chk("ack_data", {24'b0, host_dat_o}, {24'b0, mon_a.dat});
                    $display("ack cycle=%0d host_dat=%0h", cyc, host_dat_o);
                end
            end
            if (init_done_o && !prev_done) begin
                if (rise_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done_rise: got rise cycle %0d required none", cyc);
                end else begin
                    chk("done_rise_cycle", cyc, rise_q.pop_front());
                    $display("init_done rise cycle=%0d", cyc);
                end
            end
            if (!init_done_o && prev_done) begin
                if (fall_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done_fall: got fall cycle %0d required none", cyc);
                end else begin
                    chk("done_fall_cycle", cyc, fall_q.pop_front());
                    $display("init_done fall cycle=%0d", cyc);
                end
            end
        end
        prev_done <= init_done_o;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int a;
        int a2;
        int gap;
        repeat (2) @(posedge clk);
        #1;
        do_reset(base);
        start_init(base);

        host_access(1'b0, AW'(0), 8'h00, 8'hA5, 1'b0, 1'b0);
        host_access(1'b1, AW'(3), 8'h83, 8'h00, 1'b0, 1'b0);
        host_access(1'b1, AW'(0), 8'h55, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            host_access(1'($urandom), AW'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                        1'b0, 1'b0);
        end

        host_access(1'b1, AW'(4), 8'h1F, 8'h00, 1'b0, 1'b1);
        host_access(1'b0, AW'(5), 8'h00, 8'($urandom), 1'b0, 1'b0);

        // Reinit from idle, then a second reinit while that sequence is running.
        while (cyc < free_cyc) begin
            @(posedge clk);
            #1;
        end
        r = cyc;
        reinit_i = 1'b1;
        @(posedge clk);
        #1 reinit_i = 1'b0;
        a = r + 1;
        fall_q.push_back(a + 1);
        push_init(a, NW);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reinit_i = 1'b1;
        @(posedge clk);
        #1 reinit_i = 1'b0;
        a2 = a + NW + 1;
        start_init(a2);
        host_access(1'b0, AW'(2), 8'h00, 8'h5A, 1'b0, 1'b0);
        host_access(1'b1, AW'(7), 8'hE1, 8'h00, 1'b0, 1'b0);

        // Host request raised during init is held off until init_done rises.
        @(posedge clk);
        #1;
        do_reset(base);
        start_init(base);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        host_access(1'b0, AW'(6), 8'h00, 8'h3C, 1'b1, 1'b0);

        // Reset during W_DLM aborts the sequence; it restarts from BOOT.
        @(posedge clk);
        #1;
        do_reset(base);
        push_init(base, 2);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        do_reset(base);
        start_init(base);
        host_access(1'b1, AW'(1), 8'h0F, 8'h00, 1'b0, 1'b0);
        host_access(1'b0, AW'(0), 8'h00, 8'hC3, 1'b0, 1'b0);

        repeat (6) @(posedge clk);
        #1;
        chk("final_leftover", uq.size() + aq.size() + rise_q.size() + fall_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
